axis_cdc_handshake_rx: RTL and testbench

- Destination-side receiver for a two-phase (toggle) request/acknowledge CDC link carrying words into the i_new_clk domain.
- Consumes the request toggle after it has passed through the team's multi-flop synchronizer.
- Samples the source-held, quasi-static data bus and buffers words in a small FIFO.
- Presents words as an AXI-Stream master and returns an acknowledge toggle for synchronization back to the source domain.

---
 rtl/axis_cdc_handshake_rx.sv | 84 ++++++++
 tb/tb_axis_cdc_handshake_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cdc_handshake_rx.sv
`default_nettype none
// ============================================================================
// axis_cdc_handshake_rx : toggle req/ack CDC receiver feeding an AXI-Stream FIFO
// Revision: 1.0
// ============================================================================
module axis_cdc_handshake_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  i_new_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req_sync,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ack_toggle,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [CNT_W-1:0]      o_count
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_req_seen;
  logic                  r_ack;

  logic w_valid;
  logic w_full;
  logic w_pending;
  logic w_pop;
  logic w_push;

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == c_DEPTH);
  // A new word is waiting whenever the synchronized toggle differs from the last one consumed.
  assign w_pending = i_req_sync ^ r_req_seen;
  assign w_pop     = w_valid & i_tready;
  assign w_push    = w_pending & (~w_full | w_pop);

  always_ff @(posedge i_new_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_req_seen <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
        r_req_seen <= i_req_sync;
        r_ack      <= ~r_ack;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left uninitialised; the read mux is gated so empty reads show zero.
  always_ff @(posedge i_new_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_tdata      = w_valid ? r_mem[r_rd_ptr] : '0;
  assign o_tvalid     = w_valid;
  assign o_count      = r_count;
  assign o_ack_toggle = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_axis_cdc_handshake_rx.sv
`default_nettype none
// Bench for axis_cdc_handshake_rx: vector table, hand sequences, randomized CDC traffic.
module tb_axis_cdc_handshake_rx;

  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic src_clk = 1'b0;
  always #5 clk = ~clk;
  always #7 src_clk = ~src_clk;

  logic       rst_n = 1'b1;
  logic       req_drv = 1'b0;
  logic [7:0] data_drv = 8'h00;
  logic       tready = 1'b0;
  logic       use_src = 1'b0;
  logic       src_req = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic       fwd_s1, fwd_s2, ack_s1, ack_s2;
  logic       req_sync;
  logic [7:0] data_in;

  logic       ack;
  logic [7:0] tdata;
  logic       tvalid;
  logic [1:0] count;

  logic       req4 = 1'b0;
  logic [7:0] data4 = 8'h00;
  logic       tready4 = 1'b0;
  logic       ack4;
  logic [7:0] tdata4;
  logic       tvalid4;
  logic [2:0] count4;

  assign req_sync = use_src ? fwd_s2 : req_drv;
  assign data_in  = use_src ? src_data : data_drv;

  axis_cdc_handshake_rx #(.DATA_WIDTH(8), .DEPTH(2)) dut (
    .i_new_clk(clk), .i_reset_n(rst_n), .i_req_sync(req_sync), .i_data(data_in),
    .o_ack_toggle(ack), .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready),
    .o_count(count)
  );

  axis_cdc_handshake_rx #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (
    .i_new_clk(clk), .i_reset_n(rst_n), .i_req_sync(req4), .i_data(data4),
    .o_ack_toggle(ack4), .o_tdata(tdata4), .o_tvalid(tvalid4), .i_tready(tready4),
    .o_count(count4)
  );

  // Two-flop synchronizers of the CDC link: req into clk, ack into src_clk.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin fwd_s1 <= 1'b0; fwd_s2 <= 1'b0; end
    else begin fwd_s1 <= src_req; fwd_s2 <= fwd_s1; end
  end
  always @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin ack_s1 <= 1'b0; ack_s2 <= 1'b0; end
    else begin ack_s1 <= ack; ack_s2 <= ack_s1; end
  end

  int n_pass = 0;
  int n_total = 0;
  int bound_err = 0;
  int ack_tog = 0;
  logic ack_d = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Occupancy must never exceed the FIFO depth.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (count <= 2'd2 && count4 <= 3'd4) else bound_err <= bound_err + 1;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_tog <= 0;
      ack_d   <= 1'b0;
    end else begin
      if (use_src && ack !== ack_d) ack_tog <= ack_tog + 1;
      ack_d <= ack;
    end
  end

  typedef struct packed {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       ev;
    logic [7:0] etd;
    logic       eack;
    logic [1:0] ecnt;
  } vec_t;

  vec_t tv [12];

  logic [7:0] exp_q [$];
  logic [7:0] q4 [$];
  int rcvd = 0;
  int sent = 0;
  int stab_err = 0;
  int sent4 = 0;
  int got4 = 0;
  int peak4 = 0;

  initial begin
    tv[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 2'd1};
    tv[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
    tv[2]  = '{1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 2'd1};
    tv[3]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 2'd2};
    tv[4]  = '{1'b0, 8'h33, 1'b0, 1'b1, 8'h11, 1'b1, 2'd2};
    tv[5]  = '{1'b0, 8'h33, 1'b0, 1'b1, 8'h11, 1'b1, 2'd2};
    tv[6]  = '{1'b0, 8'h33, 1'b1, 1'b1, 8'h22, 1'b0, 2'd2};
    tv[7]  = '{1'b0, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 2'd1};
    tv[8]  = '{1'b0, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    tv[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h44, 1'b1, 2'd1};
    tv[10] = '{1'b0, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 2'd1};
    tv[11] = '{1'b0, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};

    #2 rst_n = 1'b0;
    #1;
    check("reset_valid", {31'd0, tvalid}, 32'd0);
    check("reset_tdata", {24'd0, tdata}, 32'd0);
    check("reset_ack",   {31'd0, ack}, 32'd0);
    check("reset_count", {30'd0, count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_drv = tv[i].req; data_drv = tv[i].data; tready = tv[i].rdy;
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), {31'd0, tvalid}, {31'd0, tv[i].ev});
      check($sformatf("vec%0d_ack", i),   {31'd0, ack},    {31'd0, tv[i].eack});
      check($sformatf("vec%0d_count", i), {30'd0, count},  {30'd0, tv[i].ecnt});
      if (tv[i].ev) check($sformatf("vec%0d_tdata", i), {24'd0, tdata}, {24'd0, tv[i].etd});
    end

    // Asynchronous reset while two words are buffered.
    @(negedge clk); req_drv = 1'b1; data_drv = 8'h77; tready = 1'b0;
    @(negedge clk); req_drv = 1'b0; data_drv = 8'h88;
    @(negedge clk);
    check("midrst_pre_count", {30'd0, count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, tvalid}, 32'd0);
    check("midrst_count", {30'd0, count}, 32'd0);
    check("midrst_ack",   {31'd0, ack}, 32'd0);
    req_drv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); req_drv = 1'b1; data_drv = 8'h5A; tready = 1'b1;
    @(posedge clk); #1;
    check("postrst_valid", {31'd0, tvalid}, 32'd1);
    check("postrst_tdata", {24'd0, tdata}, 32'h5A);
    check("postrst_ack",   {31'd0, ack}, 32'd1);

    // Randomized traffic through the synchronizers with a toggle-protocol source.
    @(negedge clk); rst_n = 1'b0; use_src = 1'b1; src_req = 1'b0; tready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    fork
      begin : source
        int sc = 0;
        while (sent < N_RAND && sc < 60000) begin
          @(negedge src_clk); sc++;
          if (ack_s2 == src_req) begin
            src_data = 8'($urandom);
            exp_q.push_back(src_data);
            src_req = ~src_req;
            sent++;
          end
        end
      end
      begin : sink
        int cyc = 0;
        logic [7:0] held = 8'h00;
        logic hold_chk = 1'b0;
        while (rcvd < N_RAND && cyc < 80000) begin
          @(negedge clk); cyc++;
          if (hold_chk && !(tvalid === 1'b1 && tdata === held)) stab_err++;
          tready = ($urandom_range(0, 3) != 0);
          if (tvalid && tready) begin
            if (exp_q.size() == 0) check("sb_unexpected_word", {24'd0, tdata}, 32'hFFFF_FFFF);
            else check($sformatf("sb_word%0d", rcvd), {24'd0, tdata}, {24'd0, exp_q.pop_front()});
            rcvd++;
          end
          hold_chk = tvalid && !tready;
          held = tdata;
        end
      end
    join
    @(negedge clk);
    check("rand_words_received", rcvd, N_RAND);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_tdata_stable", stab_err, 0);
    check("rand_ack_toggles", ack_tog, N_RAND);
    check("rand_ack_parity", {31'd0, ack}, N_RAND % 2);
    use_src = 1'b0; tready = 1'b0;

    // DEPTH=4: fill, stall with a pending fifth word, then drain while sending the rest.
    for (int c = 0; c < 400 && got4 < 9; c++) begin
      @(negedge clk);
      if (int'(count4) > peak4) peak4 = int'(count4);
      if (c == 12) begin
        check("d4_full_count", {29'd0, count4}, 32'd4);
        check("d4_stall_ack", {31'd0, ack4}, 32'd0);
        check("d4_pending_req", {31'd0, req4}, 32'd1);
      end
      tready4 = (c >= 12) && ($urandom_range(0, 2) != 0);
      if (tvalid4 && tready4) begin
        if (q4.size() == 0) check("d4_unexpected_word", {24'd0, tdata4}, 32'hFFFF_FFFF);
        else check($sformatf("d4_word%0d", got4), {24'd0, tdata4}, {24'd0, q4.pop_front()});
        got4++;
      end
      if (ack4 == req4 && sent4 < 9) begin
        data4 = 8'hC0 + 8'(sent4);
        q4.push_back(data4);
        req4 = ~req4;
        sent4++;
      end
    end
    check("d4_all_delivered", got4, 9);
    check("d4_peak_count", peak4, 4);
    check("count_bound", bound_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
